hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. It generates every per-stage stall and flush strobe consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers four sources: load-use hazards, taken branch/jump redirects from EX, fixed-latency multi-cycle EX operations (M-extension mul/div), and data-memory wait states. It holds the only sequential hazard state in the core: the multi-cycle FSM/counter and the memory-wait timeout counter.

---
 rtl/hazard_ctrl_pkg.sv | 38 +++
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The load-use test lives here so other pipeline blocks can reuse it.
package hazard_ctrl_pkg;

   localparam logic [6:0] OP_LOAD = 7'b0000011;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MC_BUSY = 1'b1
   } hz_state_e;

   typedef struct packed {
      logic stall_pc;
      logic stall_if_id;
      logic stall_id_ex;
      logic stall_ex_mem;
      logic flush_if_id;
      logic flush_id_ex;
      logic flush_ex_mem;
      logic flush_mem_wb;
   } hz_strobes_t;

   // A load in EX whose rd feeds the ID instruction cannot forward in time.
   function automatic logic is_load_use(
      input logic [6:0] ex_opcode,
      input logic       ex_rd_we,
      input logic [4:0] ex_rd_addr,
      input logic       rs1_re,
      input logic [4:0] rs1_addr,
      input logic       rs2_re,
      input logic [4:0] rs2_addr
   );
      return (ex_opcode == OP_LOAD) && ex_rd_we && (ex_rd_addr != 5'd0) &&
             ((rs1_re && (rs1_addr == ex_rd_addr)) ||
              (rs2_re && (rs2_addr == ex_rd_addr)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface hazard_ctrl_if;

   logic       id_rs1_re;
   logic       id_rs2_re;
   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic [6:0] ex_opcode;
   logic       ex_rd_we;
   logic [4:0] ex_rd_addr;
   logic       ex_mc_op;
   logic       ex_redirect;
   logic       mem_req;
   logic       mem_ready;

   logic       stall_pc;
   logic       stall_if_id;
   logic       stall_id_ex;
   logic       stall_ex_mem;
   logic       flush_if_id;
   logic       flush_id_ex;
   logic       flush_ex_mem;
   logic       flush_mem_wb;
   logic       mc_done;
   logic       mem_timeout;
   logic       mc_busy;

   modport master (
      output id_rs1_re, id_rs2_re, id_rs1_addr, id_rs2_addr,
             ex_opcode, ex_rd_we, ex_rd_addr, ex_mc_op, ex_redirect,
             mem_req, mem_ready,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             mc_done, mem_timeout, mc_busy
   );

   modport slave (
      input  id_rs1_re, id_rs2_re, id_rs1_addr, id_rs2_addr,
             ex_opcode, ex_rd_we, ex_rd_addr, ex_mc_op, ex_redirect,
             mem_req, mem_ready,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             mc_done, mem_timeout, mc_busy
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush strobes for the 5-stage
// core, the multi-cycle EX occupancy FSM and the memory-wait timeout monitor.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MC_LAT      = 4,
   parameter int unsigned MEM_TIMEOUT = 256
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hz
);

   localparam int unsigned CNT_W = $clog2(MC_LAT + 1);
   localparam int unsigned TO_W  = $clog2(MEM_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(MEM_TIMEOUT);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]  tcnt_q, tcnt_d;
   logic             timeout_q, timeout_d;

   logic        mem_wait;
   logic        load_use;
   logic        mc_stall;
   logic        mc_done;
   hz_strobes_t str;

   assign mem_wait = hz.mem_req & ~hz.mem_ready;
   assign load_use = is_load_use(hz.ex_opcode, hz.ex_rd_we, hz.ex_rd_addr,
                                 hz.id_rs1_re, hz.id_rs1_addr,
                                 hz.id_rs2_re, hz.id_rs2_addr);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of process order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mc_stall = 1'b0;
      mc_done  = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (hz.ex_mc_op) begin
               mc_stall = 1'b1;
               cnt_d    = CNT_LOAD;
               state_d  = ST_MC_BUSY;
            end
         end
         ST_MC_BUSY: begin
            if (cnt_q != '0) begin
               mc_stall = 1'b1;
               cnt_d    = cnt_q - 1'b1;
            end else if (!mem_wait) begin
               mc_done = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // The run length saturates so a very long wait cannot wrap back to zero.
   always_comb begin
      tcnt_d = '0;
      if (mem_wait) begin
         tcnt_d = (tcnt_q == TO_MAX) ? tcnt_q : tcnt_q + 1'b1;
      end
      timeout_d = timeout_q | (tcnt_d == TO_MAX);
   end

   always_comb begin
      str = '0;
      if (mem_wait) begin
         str.stall_pc     = 1'b1;
         str.stall_if_id  = 1'b1;
         str.stall_id_ex  = 1'b1;
         str.stall_ex_mem = 1'b1;
         str.flush_mem_wb = 1'b1;
      end else if (mc_stall) begin
         str.stall_pc     = 1'b1;
         str.stall_if_id  = 1'b1;
         str.stall_id_ex  = 1'b1;
         str.flush_ex_mem = 1'b1;
      end else if (hz.ex_redirect) begin
         str.flush_if_id  = 1'b1;
         str.flush_id_ex  = 1'b1;
      end else if (load_use) begin
         str.stall_pc     = 1'b1;
         str.stall_if_id  = 1'b1;
         str.flush_id_ex  = 1'b1;
      end
      if (rst) begin
         str = '0;
      end
   end

   assign hz.stall_pc     = str.stall_pc;
   assign hz.stall_if_id  = str.stall_if_id;
   assign hz.stall_id_ex  = str.stall_id_ex;
   assign hz.stall_ex_mem = str.stall_ex_mem;
   assign hz.flush_if_id  = str.flush_if_id;
   assign hz.flush_id_ex  = str.flush_id_ex;
   assign hz.flush_ex_mem = str.flush_ex_mem;
   assign hz.flush_mem_wb = str.flush_mem_wb;
   assign hz.mc_done      = mc_done & ~rst;
   assign hz.mc_busy      = (state_q == ST_MC_BUSY) & ~rst;
   assign hz.mem_timeout  = timeout_d & ~rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MC_LAT=4 and MC_LAT=2) share one
// stimulus stream and are checked against a cycle-level model of the rules.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int TO    = 8;
   localparam int LAT_A = 4;
   localparam int LAT_B = 2;
   localparam logic [6:0] OP_REG = 7'b0110011;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_rs1_re, id_rs2_re;
   logic [4:0] id_rs1_addr, id_rs2_addr;
   logic [6:0] ex_opcode;
   logic       ex_rd_we;
   logic [4:0] ex_rd_addr;
   logic       ex_mc_op, ex_redirect, mem_req, mem_ready;

   // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
   //  flush_id_ex, flush_ex_mem, flush_mem_wb, mc_done, mc_busy, mem_timeout}
   logic [10:0] obs [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit m_active [2];
   int m_elapsed [2];
   int m_wait_run;
   bit m_sticky;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      hazard_ctrl_if hz_i ();

      hazard_ctrl #(
         .MC_LAT      ((g == 0) ? LAT_A : LAT_B),
         .MEM_TIMEOUT (TO)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .hz  (hz_i)
      );

      assign hz_i.id_rs1_re   = id_rs1_re;
      assign hz_i.id_rs2_re   = id_rs2_re;
      assign hz_i.id_rs1_addr = id_rs1_addr;
      assign hz_i.id_rs2_addr = id_rs2_addr;
      assign hz_i.ex_opcode   = ex_opcode;
      assign hz_i.ex_rd_we    = ex_rd_we;
      assign hz_i.ex_rd_addr  = ex_rd_addr;
      assign hz_i.ex_mc_op    = ex_mc_op;
      assign hz_i.ex_redirect = ex_redirect;
      assign hz_i.mem_req     = mem_req;
      assign hz_i.mem_ready   = mem_ready;

      assign obs[g] = {hz_i.stall_pc, hz_i.stall_if_id, hz_i.stall_id_ex,
                       hz_i.stall_ex_mem, hz_i.flush_if_id, hz_i.flush_id_ex,
                       hz_i.flush_ex_mem, hz_i.flush_mem_wb, hz_i.mc_done,
                       hz_i.mc_busy, hz_i.mem_timeout};
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT_A : LAT_B;
   endfunction

   // Expected strobes from the priority rules and the model's occupancy view.
   function automatic logic [10:0] exp_vec(input int k);
      logic [10:0] e;
      bit mw, lu, mcs, done, tmo;
      e = '0;
      if (rst) return e;
      mw   = mem_req && !mem_ready;
      lu   = (ex_opcode == 7'h03) && ex_rd_we && (ex_rd_addr != 0) &&
             ((id_rs1_re && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_re && id_rs2_addr == ex_rd_addr));
      mcs  = (!m_active[k] && ex_mc_op) ||
             (m_active[k] && m_elapsed[k] < lat_of(k));
      done = m_active[k] && m_elapsed[k] >= lat_of(k) && !mw;
      tmo  = m_sticky || (mw && (m_wait_run + 1 >= TO));
      if (mw) begin
         e[10:7] = 4'b1111;
         e[3]    = 1'b1;
      end else if (mcs) begin
         e[10:8] = 3'b111;
         e[4]    = 1'b1;
      end else if (ex_redirect) begin
         e[6] = 1'b1;
         e[5] = 1'b1;
      end else if (lu) begin
         e[10] = 1'b1;
         e[9]  = 1'b1;
         e[5]  = 1'b1;
      end
      e[2] = done;
      e[1] = m_active[k];
      e[0] = tmo;
      return e;
   endfunction

   task automatic model_update();
      bit mw;
      mw = mem_req && !mem_ready;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_active[k]  = 0;
            m_elapsed[k] = 0;
         end else if (!m_active[k]) begin
            if (ex_mc_op) begin
               m_active[k]  = 1;
               m_elapsed[k] = 1;
            end
         end else if (m_elapsed[k] >= lat_of(k) && !mw) begin
            m_active[k] = 0;
         end else if (m_elapsed[k] < lat_of(k)) begin
            m_elapsed[k]++;
         end
      end
      if (rst) begin
         m_wait_run = 0;
         m_sticky   = 0;
      end else if (mw) begin
         m_wait_run++;
         if (m_wait_run >= TO) m_sticky = 1;
      end else begin
         m_wait_run = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic idle();
      id_rs1_re   = 0; id_rs2_re   = 0;
      id_rs1_addr = 0; id_rs2_addr = 0;
      ex_opcode   = OP_REG;
      ex_rd_we    = 0; ex_rd_addr  = 0;
      ex_mc_op    = 0; ex_redirect = 0;
      mem_req     = 0; mem_ready   = 0;
   endtask

   task automatic set_load(input logic [4:0] rd, input logic re1,
                           input logic [4:0] a1, input logic re2,
                           input logic [4:0] a2);
      ex_opcode = 7'h03; ex_rd_we = 1; ex_rd_addr = rd;
      id_rs1_re = re1; id_rs1_addr = a1;
      id_rs2_re = re2; id_rs2_addr = a2;
   endtask

   task automatic test_reset();
      idle();
      rst = 1; mem_req = 1; ex_mc_op = 1; ex_redirect = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 11'b0) begin
               bad++;
               $display("FAIL reset_hold dut%0d got=%b want=%b", k, obs[k], 11'b0);
            end
         end
         step();
      end
      rst = 0; idle();
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== 11'b0) begin
            bad++;
            $display("FAIL reset_idle dut%0d got=%b want=%b", k, obs[k], 11'b0);
         end
      end
      step();
   endtask

   task automatic test_load_use();
      logic [10:0] want [5];
      want = '{11'b11000100000, 11'b0, 11'b0, 11'b11000100000, 11'b0};
      for (int i = 0; i < 5; i++) begin
         idle();
         case (i)
            0: set_load(5'd5, 1, 5'd5, 0, 5'd0);
            1: begin id_rs1_re = 1; id_rs1_addr = 5'd5; end
            2: set_load(5'd0, 1, 5'd0, 1, 5'd0);
            3: set_load(5'd7, 1, 5'd3, 1, 5'd7);
            default: set_load(5'd7, 1, 5'd3, 0, 5'd7);
         endcase
         #1;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== want[i]) begin
               bad++;
               $display("FAIL load_use[%0d] dut%0d got=%b want=%b", i, k, obs[k], want[i]);
            end
         end
         step();
      end
   endtask

   task automatic test_redirect();
      idle();
      set_load(5'd5, 1, 5'd5, 0, 5'd0);
      ex_redirect = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== 11'b00001100000) begin
            bad++;
            $display("FAIL redirect_over_lu dut%0d got=%b want=%b", k, obs[k], 11'b00001100000);
         end
      end
      step();
   endtask

   task automatic test_multicycle();
      logic [10:0] want;
      for (int i = 0; i < 5; i++) begin
         idle();
         ex_mc_op = 1;
         want = (i == 0) ? 11'b11100010000 :
                (i < 4)  ? 11'b11100010010 : 11'b00000000110;
         #1;
         total++;
         if (obs[0] !== want) begin
            bad++;
            $display("FAIL mc_lat4[%0d] got=%b want=%b", i, obs[0], want);
         end
         total++;
         if (obs[1][2] !== (i == 2)) begin
            bad++;
            $display("FAIL mc_lat2_done[%0d] got=%b want=%b", i, obs[1][2], (i == 2));
         end
         step();
      end
      idle();
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_mem_wait_redirect();
      logic [10:0] want;
      for (int i = 0; i < 4; i++) begin
         idle();
         mem_req = 1; mem_ready = (i == 3); ex_redirect = 1;
         want = (i < 3) ? 11'b11110001000 : 11'b00001100000;
         #1;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== want) begin
               bad++;
               $display("FAIL wait_redirect[%0d] dut%0d got=%b want=%b", i, k, obs[k], want);
            end
         end
         step();
      end
   endtask

   task automatic test_mc_mem_overlap();
      logic [10:0] want [6];
      want = '{11'b11100010000, 11'b11100010010, 11'b11110001010,
               11'b11110001010, 11'b00000000110, 11'b0};
      for (int i = 0; i < 6; i++) begin
         idle();
         ex_mc_op = (i < 5);
         mem_req  = (i == 2 || i == 3);
         #1;
         total++;
         if (obs[1] !== want[i]) begin
            bad++;
            $display("FAIL mc_overlap_lat2[%0d] got=%b want=%b", i, obs[1], want[i]);
         end
         total++;
         if (obs[0][2] !== (i == 4)) begin
            bad++;
            $display("FAIL mc_overlap_lat4_done[%0d] got=%b want=%b", i, obs[0][2], (i == 4));
         end
         step();
      end
   endtask

   task automatic test_timeout_and_reset();
      for (int i = 1; i <= 12; i++) begin
         idle();
         mem_req = 1; mem_ready = (i > 10);
         #1;
         total++;
         if (obs[0][0] !== (i >= 8)) begin
            bad++;
            $display("FAIL timeout[%0d] got=%b want=%b", i, obs[0][0], (i >= 8));
         end
         step();
      end
      for (int i = 0; i < 4; i++) begin
         idle();
         ex_mc_op = (i == 0);
         rst      = (i == 2);
         #1;
         if (i >= 2) begin
            for (int k = 0; k < 2; k++) begin
               total++;
               if (obs[k] !== 11'b0) begin
                  bad++;
                  $display("FAIL rst_in_busy[%0d] dut%0d got=%b want=%b", i, k, obs[k], 11'b0);
               end
            end
         end else if (i == 1) begin
            total++;
            if (obs[0] !== 11'b11100010011) begin
               bad++;
               $display("FAIL busy_before_rst got=%b want=%b", obs[0], 11'b11100010011);
            end
         end
         step();
      end
      rst = 0;
   endtask

   task automatic test_random();
      logic [10:0] e;
      for (int n = 0; n < 1500; n++) begin
         rst         = ($urandom_range(0, 99) < 2);
         ex_opcode   = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'($urandom);
         ex_rd_we    = 1'($urandom);
         ex_rd_addr  = 5'($urandom_range(0, 3));
         id_rs1_re   = 1'($urandom);
         id_rs2_re   = 1'($urandom);
         id_rs1_addr = 5'($urandom_range(0, 3));
         id_rs2_addr = 5'($urandom_range(0, 3));
         ex_mc_op    = ($urandom_range(0, 99) < 15);
         ex_redirect = ($urandom_range(0, 99) < 15);
         mem_req     = ($urandom_range(0, 99) < 35);
         mem_ready   = ($urandom_range(0, 99) < 40);
         #1;
         for (int k = 0; k < 2; k++) begin
            e = exp_vec(k);
            total++;
            if (obs[k] !== e) begin
               bad++;
               $display("FAIL random cyc%0d dut%0d got=%b want=%b", cyc, k, obs[k], e);
            end
            total++;
            if ((obs[k][9] & obs[k][6]) | (obs[k][8] & obs[k][5]) | (obs[k][7] & obs[k][4])) begin
               bad++;
               $display("FAIL stall_flush_overlap cyc%0d dut%0d got=%b want=no_overlap", cyc, k, obs[k]);
            end
         end
         step();
      end
      rst = 0;
   endtask

   initial begin
      m_active   = '{0, 0};
      m_elapsed  = '{0, 0};
      m_wait_run = 0;
      m_sticky   = 0;
      test_reset();
      test_load_use();
      test_redirect();
      test_multicycle();
      test_mem_wait_redirect();
      test_mc_mem_overlap();
      test_timeout_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
